// File: rtl/id_exe_reg_pkg.sv
// Shared core definitions for the ARM pipeline: datapath widths, ALU command
// encodings and the packed ID/EXE slot layout.
package id_exe_reg_pkg;

   localparam int WORD_W     = 32;
   localparam int REG_IDX_W  = 4;
   localparam int SHIFT_OP_W = 12;
   localparam int EXE_CMD_W  = 4;

   typedef logic [EXE_CMD_W-1:0] exe_cmd_t;

   // Several mnemonics share an ALU operation, so these are constants rather than an enum
   localparam exe_cmd_t EXE_NOP = 4'b0000;
   localparam exe_cmd_t EXE_MOV = 4'b0001;
   localparam exe_cmd_t EXE_MVN = 4'b1001;
   localparam exe_cmd_t EXE_ADD = 4'b0010;
   localparam exe_cmd_t EXE_ADC = 4'b0011;
   localparam exe_cmd_t EXE_SUB = 4'b0100;
   localparam exe_cmd_t EXE_SBC = 4'b0101;
   localparam exe_cmd_t EXE_AND = 4'b0110;
   localparam exe_cmd_t EXE_ORR = 4'b0111;
   localparam exe_cmd_t EXE_EOR = 4'b1000;
   localparam exe_cmd_t EXE_CMP = 4'b0100;
   localparam exe_cmd_t EXE_TST = 4'b0110;
   localparam exe_cmd_t EXE_LDR = 4'b0010;
   localparam exe_cmd_t EXE_STR = 4'b0010;

   typedef struct packed {
      logic                  valid;
      logic [WORD_W-1:0]     pc;
      logic [WORD_W-1:0]     valRn;
      logic [WORD_W-1:0]     valRm;
      logic [SHIFT_OP_W-1:0] shiftOperand;
      logic                  imm;
      exe_cmd_t              exeCmd;
      logic                  memREn;
      logic                  memWEn;
      logic                  wbEn;
      logic                  b;
      logic                  s;
      logic                  los;
      logic [REG_IDX_W-1:0]  dest;
      logic [REG_IDX_W-1:0]  src1;
      logic [REG_IDX_W-1:0]  src2;
      logic                  carry;
   } exe_slot_t;

   function automatic exe_slot_t bubbleSlot();
      exe_slot_t slot;
      slot        = '0;
      slot.exeCmd = EXE_NOP;
      return slot;
   endfunction

endpackage

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register: captures decoded fields and operands at the end of
// ID, with stall (hold), flush (bubble) and a valid bit for squashed slots.
module id_exe_reg
   import id_exe_reg_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  id_valid,
   input  logic [WORD_W-1:0]     id_pc,
   input  logic [WORD_W-1:0]     id_val_rn,
   input  logic [WORD_W-1:0]     id_val_rm,
   input  logic [SHIFT_OP_W-1:0] id_shift_operand,
   input  logic                  id_imm,
   input  logic [EXE_CMD_W-1:0]  id_exe_cmd,
   input  logic                  id_mem_r_en,
   input  logic                  id_mem_w_en,
   input  logic                  id_wb_en,
   input  logic                  id_b,
   input  logic                  id_s,
   input  logic [REG_IDX_W-1:0]  id_dest,
   input  logic [REG_IDX_W-1:0]  id_src1,
   input  logic [REG_IDX_W-1:0]  id_src2,
   input  logic                  id_carry,
   output logic                  exe_valid,
   output logic                  exe_los,
   output logic [WORD_W-1:0]     exe_pc,
   output logic [WORD_W-1:0]     exe_val_rn,
   output logic [WORD_W-1:0]     exe_val_rm,
   output logic [SHIFT_OP_W-1:0] exe_shift_operand,
   output logic                  exe_imm,
   output logic [EXE_CMD_W-1:0]  exe_exe_cmd,
   output logic                  exe_mem_r_en,
   output logic                  exe_mem_w_en,
   output logic                  exe_wb_en,
   output logic                  exe_b,
   output logic                  exe_s,
   output logic [REG_IDX_W-1:0]  exe_dest,
   output logic [REG_IDX_W-1:0]  exe_src1,
   output logic [REG_IDX_W-1:0]  exe_src2,
   output logic                  exe_carry
);

   exe_slot_t r_slot;
   exe_slot_t w_loadSlot;
   exe_slot_t w_nextSlot;

   // An invalid ID slot still carries its data, but none of its side effects
   always_comb begin
      w_loadSlot              = '0;
      w_loadSlot.valid        = id_valid;
      w_loadSlot.pc           = id_pc;
      w_loadSlot.valRn        = id_val_rn;
      w_loadSlot.valRm        = id_val_rm;
      w_loadSlot.shiftOperand = id_shift_operand;
      w_loadSlot.imm          = id_imm;
      w_loadSlot.exeCmd       = id_exe_cmd;
      w_loadSlot.memREn       = id_valid & id_mem_r_en;
      w_loadSlot.memWEn       = id_valid & id_mem_w_en;
      w_loadSlot.wbEn         = id_valid & id_wb_en;
      w_loadSlot.b            = id_valid & id_b;
      w_loadSlot.s            = id_valid & id_s;
      w_loadSlot.los          = id_valid & (id_mem_r_en | id_mem_w_en);
      w_loadSlot.dest         = id_dest;
      w_loadSlot.src1         = id_src1;
      w_loadSlot.src2         = id_src2;
      w_loadSlot.carry        = id_carry;
   end

   // Flush beats stall so a stalled instruction behind a taken branch is discarded
   always_comb begin
      w_nextSlot = w_loadSlot;
      if (flush) begin
         w_nextSlot = bubbleSlot();
      end else if (stall) begin
         w_nextSlot = r_slot;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_slot <= bubbleSlot();
      end else begin
         r_slot <= w_nextSlot;
      end
   end

   assign exe_valid         = r_slot.valid;
   assign exe_los           = r_slot.los;
   assign exe_pc            = r_slot.pc;
   assign exe_val_rn        = r_slot.valRn;
   assign exe_val_rm        = r_slot.valRm;
   assign exe_shift_operand = r_slot.shiftOperand;
   assign exe_imm           = r_slot.imm;
   assign exe_exe_cmd       = r_slot.exeCmd;
   assign exe_mem_r_en      = r_slot.memREn;
   assign exe_mem_w_en      = r_slot.memWEn;
   assign exe_wb_en         = r_slot.wbEn;
   assign exe_b             = r_slot.b;
   assign exe_s             = r_slot.s;
   assign exe_dest          = r_slot.dest;
   assign exe_src1          = r_slot.src1;
   assign exe_src2          = r_slot.src2;
   assign exe_carry         = r_slot.carry;

   // A squashed slot must never write, touch memory, branch or set flags
   assert property (@(posedge clk) disable iff (!rst)
      !exe_valid |-> !(exe_wb_en | exe_mem_r_en | exe_mem_w_en | exe_b | exe_s));

endmodule

// File: tb/tb_id_exe_reg.sv
// Directed self-checking bench for the ID/EXE pipeline register.
module tb_id_exe_reg;
   import id_exe_reg_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, flush, id_valid;
   logic [31:0] id_pc, id_val_rn, id_val_rm;
   logic [11:0] id_shift_operand;
   logic        id_imm;
   logic [3:0]  id_exe_cmd;
   logic        id_mem_r_en, id_mem_w_en, id_wb_en, id_b, id_s;
   logic [3:0]  id_dest, id_src1, id_src2;
   logic        id_carry;
   logic        exe_valid, exe_los;
   logic [31:0] exe_pc, exe_val_rn, exe_val_rm;
   logic [11:0] exe_shift_operand;
   logic        exe_imm;
   logic [3:0]  exe_exe_cmd;
   logic        exe_mem_r_en, exe_mem_w_en, exe_wb_en, exe_b, exe_s;
   logic [3:0]  exe_dest, exe_src1, exe_src2;
   logic        exe_carry;

   int checks   = 0;
   int failures = 0;

   logic [132:0] allOut;
   assign allOut = {exe_valid, exe_los, exe_pc, exe_val_rn, exe_val_rm, exe_shift_operand,
                    exe_imm, exe_exe_cmd, exe_mem_r_en, exe_mem_w_en, exe_wb_en, exe_b,
                    exe_s, exe_dest, exe_src1, exe_src2, exe_carry};

   id_exe_reg dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
      .id_pc(id_pc), .id_val_rn(id_val_rn), .id_val_rm(id_val_rm),
      .id_shift_operand(id_shift_operand), .id_imm(id_imm), .id_exe_cmd(id_exe_cmd),
      .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en), .id_wb_en(id_wb_en),
      .id_b(id_b), .id_s(id_s), .id_dest(id_dest), .id_src1(id_src1), .id_src2(id_src2),
      .id_carry(id_carry),
      .exe_valid(exe_valid), .exe_los(exe_los), .exe_pc(exe_pc), .exe_val_rn(exe_val_rn),
      .exe_val_rm(exe_val_rm), .exe_shift_operand(exe_shift_operand), .exe_imm(exe_imm),
      .exe_exe_cmd(exe_exe_cmd), .exe_mem_r_en(exe_mem_r_en), .exe_mem_w_en(exe_mem_w_en),
      .exe_wb_en(exe_wb_en), .exe_b(exe_b), .exe_s(exe_s), .exe_dest(exe_dest),
      .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_carry(exe_carry)
   );

   // Free-running 10-unit clock; rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Drive a quiet, valid-less ID slot with no control requests
   task automatic applyStimulus();
      stall = 0; flush = 0; id_valid = 0;
      id_pc = '0; id_val_rn = '0; id_val_rm = '0; id_shift_operand = '0; id_imm = 0;
      id_exe_cmd = EXE_NOP; id_mem_r_en = 0; id_mem_w_en = 0; id_wb_en = 0;
      id_b = 0; id_s = 0; id_dest = '0; id_src1 = '0; id_src2 = '0; id_carry = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1; stall = 0; flush = 0; id_valid = 1;
      id_pc = '1; id_val_rn = '1; id_val_rm = '1; id_shift_operand = '1; id_imm = 1;
      id_exe_cmd = '1; id_mem_r_en = 1; id_mem_w_en = 1; id_wb_en = 1;
      id_b = 1; id_s = 1; id_dest = '1; id_src1 = '1; id_src2 = '1; id_carry = 1;
      tick();
      #2 rst = 0;
      #1;
      checks++;
      if (allOut !== '0) begin
         failures++;
         $display("[TB] FAIL reset_async got=%h expected=0", allOut);
      end
      applyStimulus();
      id_valid = 1; id_pc = 32'h0000_0010;
      @(negedge clk);
      rst = 1;
      tick();
      checks++;
      if (exe_pc !== 32'h0000_0010) begin
         failures++;
         $display("[TB] FAIL reset_release_pc got=%h expected=%h", exe_pc, 32'h10);
      end
   endtask

   task automatic test_load();
      applyStimulus();
      id_valid = 1; id_mem_r_en = 1; id_shift_operand = 12'h2FF; id_imm = 1;
      id_val_rm = 32'hDEAD_BEEF; id_exe_cmd = EXE_LDR; id_carry = 1; id_src1 = 4'd3;
      tick();
      checks++;
      if ({exe_los, exe_shift_operand, exe_imm, exe_val_rm, exe_valid}
          !== {1'b1, 12'h2FF, 1'b1, 32'hDEAD_BEEF, 1'b1}) begin
         failures++;
         $display("[TB] FAIL load_fields los=%b shop=%h imm=%b rm=%h valid=%b expected 1 2ff 1 deadbeef 1",
                  exe_los, exe_shift_operand, exe_imm, exe_val_rm, exe_valid);
      end
      checks++;
      if ({exe_exe_cmd, exe_carry, exe_src1, exe_mem_r_en, exe_mem_w_en}
          !== {EXE_LDR, 1'b1, 4'd3, 1'b1, 1'b0}) begin
         failures++;
         $display("[TB] FAIL load_ctrl cmd=%h c=%b src1=%h r=%b w=%b expected 2 1 3 1 0",
                  exe_exe_cmd, exe_carry, exe_src1, exe_mem_r_en, exe_mem_w_en);
      end
   endtask

   task automatic test_stall();
      applyStimulus();
      id_valid = 1; id_pc = 32'h20; id_wb_en = 1;
      tick();
      checks++;
      if (exe_pc !== 32'h20) begin
         failures++;
         $display("[TB] FAIL stall_preload got=%h expected=20", exe_pc);
      end
      stall = 1; id_pc = 32'h24; id_valid = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({exe_pc, exe_valid, exe_wb_en} !== {32'h20, 1'b1, 1'b1}) begin
            failures++;
            $display("[TB] FAIL stall_hold_%0d pc=%h valid=%b wb=%b expected 20 1 1",
                     i, exe_pc, exe_valid, exe_wb_en);
         end
      end
      stall = 0; id_valid = 1;
      tick();
      checks++;
      if (exe_pc !== 32'h24) begin
         failures++;
         $display("[TB] FAIL stall_release got=%h expected=24", exe_pc);
      end
   endtask

   task automatic test_flush();
      applyStimulus();
      id_valid = 1; id_wb_en = 1; id_dest = 4'd5; id_exe_cmd = EXE_ADD; id_pc = 32'h30;
      flush = 1;
      tick();
      checks++;
      if ({exe_valid, exe_wb_en, exe_dest, exe_exe_cmd, exe_pc} !== {1'b0, 1'b0, 4'd0, 4'd0, 32'd0}) begin
         failures++;
         $display("[TB] FAIL flush_bubble valid=%b wb=%b dest=%h cmd=%h pc=%h expected all 0",
                  exe_valid, exe_wb_en, exe_dest, exe_exe_cmd, exe_pc);
      end
      flush = 0;
      tick();
      checks++;
      if ({exe_valid, exe_wb_en, exe_dest, exe_exe_cmd} !== {1'b1, 1'b1, 4'd5, EXE_ADD}) begin
         failures++;
         $display("[TB] FAIL flush_recover valid=%b wb=%b dest=%h cmd=%h expected 1 1 5 2",
                  exe_valid, exe_wb_en, exe_dest, exe_exe_cmd);
      end
   endtask

   task automatic test_flush_stall();
      applyStimulus();
      id_valid = 1; id_mem_w_en = 1; id_pc = 32'h40; id_val_rn = 32'h1234;
      tick();
      checks++;
      if ({exe_mem_w_en, exe_los} !== 2'b11) begin
         failures++;
         $display("[TB] FAIL flush_stall_preload w=%b los=%b expected 1 1", exe_mem_w_en, exe_los);
      end
      stall = 1; flush = 1;
      tick();
      checks++;
      if (allOut !== '0) begin
         failures++;
         $display("[TB] FAIL flush_stall_bubble got=%h expected=0", allOut);
      end
   endtask

   task automatic test_invalid();
      applyStimulus();
      id_valid = 0; id_wb_en = 1; id_b = 1; id_s = 1; id_mem_r_en = 1; id_val_rn = 32'h5;
      tick();
      checks++;
      if ({exe_valid, exe_wb_en, exe_b, exe_s, exe_los, exe_mem_r_en, exe_val_rn}
          !== {6'b000000, 32'h5}) begin
         failures++;
         $display("[TB] FAIL invalid_slot v=%b wb=%b b=%b s=%b los=%b r=%b rn=%h expected 0s rn=5",
                  exe_valid, exe_wb_en, exe_b, exe_s, exe_los, exe_mem_r_en, exe_val_rn);
      end
   endtask

   task automatic test_reset_mid_stall();
      applyStimulus();
      id_valid = 1; id_pc = 32'h50; id_b = 1;
      tick();
      stall = 1;
      #2 rst = 0;
      #1;
      checks++;
      if (allOut !== '0) begin
         failures++;
         $display("[TB] FAIL reset_mid_stall got=%h expected=0", allOut);
      end
      @(negedge clk);
      rst = 1;
      tick();
      checks++;
      if ({exe_pc, exe_valid} !== {32'd0, 1'b0}) begin
         failures++;
         $display("[TB] FAIL reset_stall_hold pc=%h valid=%b expected 0 0", exe_pc, exe_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] pcs [3];
      logic [3:0]  dests [3];
      pcs   = '{32'h100, 32'h104, 32'h108};
      dests = '{4'd1, 4'd7, 4'd14};
      applyStimulus();
      for (int i = 0; i < 3; i++) begin
         id_valid = 1; id_pc = pcs[i]; id_dest = dests[i]; id_s = i[0];
         tick();
         checks++;
         if ({exe_pc, exe_dest, exe_s, exe_valid} !== {pcs[i], dests[i], i[0], 1'b1}) begin
            failures++;
            $display("[TB] FAIL back_to_back_%0d pc=%h dest=%h s=%b valid=%b expected %h %h %b 1",
                     i, exe_pc, exe_dest, exe_s, exe_valid, pcs[i], dests[i], i[0]);
         end
      end
   endtask

   // Guard against a hung run
   initial begin
      #100000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      test_reset();
      test_load();
      test_stall();
      test_flush();
      test_flush_stall();
      test_invalid();
      test_reset_mid_stall();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
